sraml_mem_resp: RTL

SRAML_MEM_RESP -- requirements
Module: sraml_mem_resp

---
 rtl/sraml_mem_resp_pkg.sv | 29 ++
 rtl/sraml_mem_resp_if.sv | 35 +++
 rtl/sraml_resp_fifo.sv | 100 ++++++++++
 rtl/sraml_mem_resp.sv | 113 +++++++++++
 4 files changed

// File: rtl/sraml_mem_resp_pkg.sv
// -----------------------------------------------------------------------------
// sraml_mem_resp_pkg
// Shared definitions for the SRAM-like memory responder: access-size
// encodings, the bus data width and the byte-enable helper used to build the
// SRAM write strobes from an access size and the low address bits.
// -----------------------------------------------------------------------------
package sraml_mem_resp_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } size_e;

  // Size 2'b11 is treated as a full word, like SZ_WORD.
  function automatic logic [3:0] byte_en(input logic [1:0] size,
                                         input logic [1:0] addr_lo);
    logic [3:0] be;
    case (size)
      SZ_BYTE: be = 4'b0001 << addr_lo;
      SZ_HALF: be = addr_lo[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/sraml_mem_resp_if.sv
// -----------------------------------------------------------------------------
// sraml_mem_resp_if
// SRAM-like request/response bus.
//   data_req     master -> slave  request valid
//   data_wr      master -> slave  1 = write, 0 = read
//   data_size    master -> slave  access size (size_e encoding)
//   data_addr    master -> slave  byte address
//   data_wdata   master -> slave  write data, lane-replicated by the master
//   data_rdata   slave -> master  read data, meaningful only with data_data_ok
//   data_addr_ok slave -> master  address handshake accept
//   data_data_ok slave -> master  one-cycle completion pulse
// -----------------------------------------------------------------------------
interface sraml_mem_resp_if;
  import sraml_mem_resp_pkg::*;

  logic              data_req;
  logic              data_wr;
  logic [1:0]        data_size;
  logic [DATA_W-1:0] data_addr;
  logic [DATA_W-1:0] data_wdata;
  logic [DATA_W-1:0] data_rdata;
  logic              data_addr_ok;
  logic              data_data_ok;

  modport master (
    output data_req, data_wr, data_size, data_addr, data_wdata,
    input  data_rdata, data_addr_ok, data_data_ok
  );

  modport slave (
    input  data_req, data_wr, data_size, data_addr, data_wdata,
    output data_rdata, data_addr_ok, data_data_ok
  );

endinterface

// File: rtl/sraml_resp_fifo.sv
// -----------------------------------------------------------------------------
// sraml_resp_fifo
// In-order pending-transaction queue of DEPTH entries. Every entry carries a
// W-bit payload and a CW-bit countdown; all valid countdowns decrement by one
// per cycle and saturate at zero.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   i_push        append {i_push_data, i_push_cd} (ignored when full)
//   i_pop         drop the head entry (ignored when empty)
//   i_upd         overwrite the payload of the most recently pushed entry
//   i_upd_data    replacement payload for i_upd
//   o_head_data   head payload
//   o_head_cd     head countdown
//   o_full        DEPTH entries held
//   o_empty       no entries held
//   o_count       number of entries held
// -----------------------------------------------------------------------------
module sraml_resp_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 33,
  parameter int CW    = 1,
  parameter int CNTW  = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_push,
  input  logic [W-1:0]    i_push_data,
  input  logic [CW-1:0]   i_push_cd,
  input  logic            i_pop,
  input  logic            i_upd,
  input  logic [W-1:0]    i_upd_data,
  output logic [W-1:0]    o_head_data,
  output logic [CW-1:0]   o_head_cd,
  output logic            o_full,
  output logic            o_empty,
  output logic [CNTW-1:0] o_count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]    r_data [DEPTH];
  logic [CW-1:0]   r_cd   [DEPTH];
  logic [DEPTH-1:0] r_vld;
  logic [PW-1:0]   r_wptr;
  logic [PW-1:0]   r_rptr;
  logic [CNTW-1:0] r_count;
  logic [PW-1:0]   w_last;
  logic            w_push;
  logic            w_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign o_full      = (r_count == CNTW'(DEPTH));
  assign o_empty     = (r_count == '0);
  assign o_count     = r_count;
  assign o_head_data = r_data[r_rptr];
  assign o_head_cd   = r_cd[r_rptr];

  assign w_push = i_push & ~o_full;
  assign w_pop  = i_pop & ~o_empty;

  // Slot written by the previous push; a push and an update never target the
  // same slot because a slot is only reused once the queue has wrapped.
  assign w_last = (r_wptr == '0) ? PW'(DEPTH - 1) : r_wptr - 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_vld   <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_pop && r_rptr == PW'(i)) begin
          r_vld[i] <= 1'b0;
        end else if (w_push && r_wptr == PW'(i)) begin
          r_vld[i] <= 1'b1;
        end
      end
      if (w_push) r_wptr <= ptr_inc(r_wptr);
      if (w_pop)  r_rptr <= ptr_inc(r_rptr);
      r_count <= r_count + CNTW'(w_push) - CNTW'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (w_push && r_wptr == PW'(i)) begin
        r_data[i] <= i_push_data;
        r_cd[i]   <= i_push_cd;
      end else begin
        if (i_upd && w_last == PW'(i)) r_data[i] <= i_upd_data;
        if (r_vld[i] && r_cd[i] != '0) r_cd[i] <= r_cd[i] - 1'b1;
      end
    end
  end

endmodule

// File: rtl/sraml_mem_resp.sv
// -----------------------------------------------------------------------------
// sraml_mem_resp
// Fixed-latency responder bridging an SRAM-like bus onto a synchronous SRAM.
// Each accepted request drives the SRAM in the handshake cycle and completes
// with a one-cycle data_data_ok exactly LATENCY cycles later, in order.
// Parameters:
//   LATENCY  cycles from address handshake to data_data_ok (1..8)
//   DEPTH    maximum outstanding transactions (1..4)
//   AW       SRAM word-address width
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   bus        SRAM-like bus, slave side
//   ram_en     SRAM access enable (handshake cycle only)
//   ram_wen    SRAM byte write enables (writes only)
//   ram_addr   SRAM word address
//   ram_wdata  SRAM write data
//   ram_rdata  SRAM read data, valid one cycle after ram_en
// -----------------------------------------------------------------------------
module sraml_mem_resp
  import sraml_mem_resp_pkg::*;
#(
  parameter int LATENCY = 2,
  parameter int DEPTH   = 2,
  parameter int AW      = 16
) (
  input  logic              clk,
  input  logic              rst,
  sraml_mem_resp_if.slave   bus,
  output logic              ram_en,
  output logic [3:0]        ram_wen,
  output logic [AW-1:0]     ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int CW   = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int CNTW = $clog2(DEPTH + 1);
  localparam int EW   = DATA_W + 1;

  logic              w_room;
  logic              w_hs;
  logic              w_dok;
  logic              w_empty;
  logic              w_unused_full;
  logic [CNTW-1:0]   w_count;
  logic [EW-1:0]     w_head;
  logic [CW-1:0]     w_head_cd;
  logic              w_head_wr;
  logic [DATA_W-1:0] w_rdata;
  logic              r_rd_p1;

  // The count is registered, so a pop in this cycle does not open a slot
  // until the next one.
  assign w_room = (w_count < CNTW'(DEPTH));

  assign bus.data_addr_ok = bus.data_req & w_room & ~rst;
  assign w_hs             = bus.data_req & w_room & ~rst;

  // Stage p0: the SRAM is driven straight from the handshake, so writes are
  // committed at the handshake edge and a following read sees them.
  assign ram_en    = w_hs;
  assign ram_wen   = (w_hs & bus.data_wr) ? byte_en(bus.data_size, bus.data_addr[1:0])
                                          : 4'b0000;
  assign ram_addr  = bus.data_addr[AW+1:2];
  assign ram_wdata = bus.data_wdata;

  generate
    if (AW < 30) begin : g_addr_hi
      logic w_unused_addr_hi;
      assign w_unused_addr_hi = ^bus.data_addr[DATA_W-1:AW+2];
    end
  endgenerate

  // Stage p1: ram_rdata now holds the word for a read accepted last cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_rd_p1 <= 1'b0;
    else     r_rd_p1 <= w_hs & ~bus.data_wr;
  end

  // Entry payload is {wr, rdata}; rdata is filled in one cycle after push.
  sraml_resp_fifo #(
    .DEPTH (DEPTH),
    .W     (EW),
    .CW    (CW),
    .CNTW  (CNTW)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_hs),
    .i_push_data ({bus.data_wr, {DATA_W{1'b0}}}),
    .i_push_cd   (CW'(LATENCY - 1)),
    .i_pop       (w_dok),
    .i_upd       (r_rd_p1),
    .i_upd_data  ({1'b0, ram_rdata}),
    .o_head_data (w_head),
    .o_head_cd   (w_head_cd),
    .o_full      (w_unused_full),
    .o_empty     (w_empty),
    .o_count     (w_count)
  );

  // Completion: the head has waited its full latency.
  assign w_dok     = ~w_empty & (w_head_cd == '0);
  assign w_head_wr = w_head[DATA_W];

  // With LATENCY=1 the head completes before its rdata field is written,
  // so the SRAM output is forwarded directly.
  assign w_rdata = (LATENCY == 1) ? ram_rdata : w_head[DATA_W-1:0];

  assign bus.data_data_ok = w_dok;
  assign bus.data_rdata   = (w_dok & ~w_head_wr) ? w_rdata : '0;

endmodule
